encode_ctrl: RTL and testbench

//  Sequencer and parity owner for the 256-bit circulant LDPC encode cell.
//  - Accepts a message as a valid/ready byte stream and drives the cell's control inputs:
//    rst_c, en_G, load_G, en_L, addrROM and d_in.
//  - Holds the 256-bit parity accumulator that the cell reads on L_cell and writes back on L_in.
//  - Returns the finished parity word over a valid/ready handshake.
//  - Sits between the message source and the encode cell; the cell's ROM is preloaded externally.

---
 rtl/encode_ctrl.sv | 118 +++++++++++
 tb/tb_encode_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encode_ctrl.sv
// rtl/encode_ctrl.sv - sequencer and parity accumulator for the 256-bit circulant LDPC encode cell
module encode_ctrl #(
    parameter int NUM_BLK = 32,
    parameter int BLK_B   = 32,
    parameter int ADDR_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    input  logic [7:0]        msg_data,
    input  logic              msg_valid,
    output logic              msg_ready,
    output logic [7:0]        d_in,
    output logic              rst_c,
    output logic              en_G,
    output logic              load_G,
    output logic              en_L,
    output logic [ADDR_W-1:0] addrROM,
    output logic [255:0]      L_cell,
    input  logic [255:0]      L_in,
    output logic [255:0]      par_data,
    output logic              par_valid,
    input  logic              par_ready
);

    typedef enum logic [2:0] {IDLE, CLR, LOAD, DATA, DONE} state_t;

    localparam logic [4:0]        BYTE_LAST = 5'(BLK_B - 1);
    localparam logic [ADDR_W-1:0] BLK_LAST  = ADDR_W'(NUM_BLK - 1);

    state_t            state, state_nx;
    logic [255:0]      par_q;
    logic [ADDR_W-1:0] blk;
    logic [4:0]        byte_cnt;
    logic              hs, last_byte, last_blk;

    assign hs        = (state == DATA) && msg_valid;
    assign last_byte = (byte_cnt == BYTE_LAST);
    assign last_blk  = (blk == BLK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            par_q    <= '0;
            blk      <= '0;
            byte_cnt <= '0;
        end else begin
            state <= state_nx;
            case (state)
                CLR: begin
                    par_q <= '0;
                    blk   <= '0;
                end
                LOAD: byte_cnt <= '0;
                DATA: begin
                    // Without a handshake nothing moves, so a stalled source never corrupts parity.
                    if (hs) begin
                        par_q    <= L_in;
                        byte_cnt <= byte_cnt + 5'd1;
                        if (last_byte && !last_blk)
                            blk <= blk + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        busy      = 1'b1;
        msg_ready = 1'b0;
        d_in      = 8'h00;
        rst_c     = 1'b1;
        en_G      = 1'b0;
        load_G    = 1'b0;
        en_L      = 1'b0;
        addrROM   = '0;
        par_valid = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_nx = CLR;
            end
            CLR: begin
                rst_c    = 1'b0;
                state_nx = LOAD;
            end
            LOAD: begin
                en_G     = 1'b1;
                load_G   = 1'b1;
                addrROM  = blk;
                state_nx = DATA;
            end
            DATA: begin
                msg_ready = 1'b1;
                d_in      = msg_data;
                addrROM   = blk;
                en_G      = msg_valid;
                en_L      = msg_valid;
                if (hs && last_byte)
                    state_nx = last_blk ? DONE : LOAD;
            end
            DONE: begin
                par_valid = 1'b1;
                if (par_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign L_cell   = par_q;
    assign par_data = par_q;

endmodule

// File: tb/tb_encode_ctrl.sv
// tb/tb_encode_ctrl.sv - bench for encode_ctrl with a behavioural cell and GF(2) encoder model
module tb_encode_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   start, busy, msg_valid, msg_ready, rst_c, en_G, load_G, en_L, par_valid, par_ready;
    logic [7:0]   msg_data [2];
    logic [7:0]   d_in     [2];
    logic [4:0]   addr     [2];
    logic [255:0] L_cell   [2];
    logic [255:0] L_in     [2];
    logic [255:0] par_data [2];
    logic [255:0] rom      [2][32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    function automatic logic [255:0] rotl(input logic [255:0] x, input int n);
        int m;
        m = n % 256;
        if (m == 0) return x;
        return (x << m) | (x >> (256 - m));
    endfunction

    function automatic logic [255:0] cell_next(input logic [255:0] l, input logic [255:0] gb,
                                               input logic [7:0] d);
        logic [255:0] r;
        r = l;
        for (int i = 0; i < 8; i++)
            if (d[i]) r = r ^ rotl(gb, i);
        return r;
    endfunction

    // Instance 0 is the two-block codeword, instance 1 the full 32-block codeword.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int NB = (g == 0) ? 2 : 32;
        logic [255:0] gbuf;

        encode_ctrl #(.NUM_BLK(NB), .BLK_B(32), .ADDR_W(5)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .start     (start[g]),
            .busy      (busy[g]),
            .msg_data  (msg_data[g]),
            .msg_valid (msg_valid[g]),
            .msg_ready (msg_ready[g]),
            .d_in      (d_in[g]),
            .rst_c     (rst_c[g]),
            .en_G      (en_G[g]),
            .load_G    (load_G[g]),
            .en_L      (en_L[g]),
            .addrROM   (addr[g]),
            .L_cell    (L_cell[g]),
            .L_in      (L_in[g]),
            .par_data  (par_data[g]),
            .par_valid (par_valid[g]),
            .par_ready (par_ready[g])
        );

        always @(posedge clk) begin
            if (!rst_c[g])
                gbuf <= '0;
            else if (en_G[g])
                gbuf <= load_G[g] ? rom[g][addr[g]] : rotl(gbuf, 8);
        end

        assign L_in[g] = cell_next(L_cell[g], gbuf, d_in[g]);
    end

    logic [7:0] msgq[$];

    // Quasi-cyclic encoder: message bit k*8+i of block b adds ROM[b] rotated by its position.
    function automatic logic [255:0] golden(input int g);
        logic [255:0] p;
        p = '0;
        for (int k = 0; k < msgq.size(); k++)
            for (int i = 0; i < 8; i++)
                if (msgq[k][i]) p = p ^ rotl(rom[g][k / 32], (k % 32) * 8 + i);
        return p;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // snapshot bits: {busy, rst_c, en_G, load_G, en_L, msg_ready, par_valid}
    logic [6:0] snap   [200];
    logic [4:0] snap_a [200];
    int         pv_cyc, nhs;

    task automatic run_small(input int st_lo, input int st_hi, input int xstart, input int stop_at);
        msgq.delete();
        pv_cyc = -1;
        nhs    = 0;
        for (int c = 0; c < 200; c++) begin
            snap[c]   = '0;
            snap_a[c] = '0;
        end
        for (int c = 0; c < 200; c++) begin
            start[0]     = (c == 0) || (c == xstart);
            msg_valid[0] = !(c >= st_lo && c <= st_hi);
            msg_data[0]  = 8'($urandom);
            if (c == stop_at) return;
            @(negedge clk);
            snap[c]   = {busy[0], rst_c[0], en_G[0], load_G[0], en_L[0], msg_ready[0], par_valid[0]};
            snap_a[c] = addr[0];
            if (msg_valid[0] && msg_ready[0]) begin
                msgq.push_back(msg_data[0]);
                nhs++;
            end
            if (par_valid[0]) begin
                pv_cyc   = c;
                start[0] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        int         cyc;
        logic [6:0] exp;
        int         a;
    } vec_t;
    vec_t tv [9];

    initial begin
        logic [255:0] held;
        int           errs;
        int           done;
        int           hs_seen;

        rst       = 1'b1;
        start     = '0;
        msg_valid = '0;
        par_ready = '0;
        msg_data[0] = '0;
        msg_data[1] = '0;
        for (int g = 0; g < 2; g++)
            for (int b = 0; b < 32; b++)
                for (int w = 0; w < 8; w++)
                    rom[g][b][w*32 +: 32] = $urandom;

        tv[0] = '{0,  7'b0100000, -1};
        tv[1] = '{1,  7'b1000000, -1};
        tv[2] = '{2,  7'b1111000, 0};
        tv[3] = '{3,  7'b1110110, 0};
        tv[4] = '{34, 7'b1110110, 0};
        tv[5] = '{35, 7'b1111000, 1};
        tv[6] = '{36, 7'b1110110, 1};
        tv[7] = '{67, 7'b1110110, 1};
        tv[8] = '{68, 7'b1100001, -1};

        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset ctrl", {busy[g], rst_c[g], en_G[g], load_G[g], en_L[g], msg_ready[g], par_valid[g]},
                7'b0100000);
            chk("reset L_cell", L_cell[g], '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;

        // T1: reset mid-DATA at block 1, byte 10
        run_small(-1, -2, -1, 46);
        #1 chk("T1 pre-reset msg_ready", msg_ready[0], 1'b1);
        rst = 1'b1;
        #1;
        chk("T1 async reset", {msg_ready[0], rst_c[0], busy[0]}, 3'b010);
        chk("T1 L_cell cleared", L_cell[0], '0);
        @(posedge clk);
        #1 rst = 1'b0;
        run_small(-1, -2, -1, -1);
        chk("T1 clean par_valid cycle", pv_cyc, 68);
        chk("T1 clean parity", par_data[0], golden(0));
        @(posedge clk);
        #1 par_ready[0] = 1'b1;
        @(posedge clk);
        #1 par_ready[0] = 1'b0;

        // T2: msg_valid tied high, table of key cycles
        run_small(-1, -2, -1, -1);
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("T2 ctrl cycle %0d", tv[i].cyc), snap[tv[i].cyc], tv[i].exp);
            if (tv[i].a >= 0)
                chk($sformatf("T2 addr cycle %0d", tv[i].cyc), snap_a[tv[i].cyc], 5'(tv[i].a));
        end
        errs = 0;
        for (int c = 0; c <= 68; c++)
            if (snap[c][2] != ((c >= 3 && c <= 34) || (c >= 36 && c <= 67))) errs++;
        chk("T2 en_L window errors", errs, 0);
        chk("T2 handshakes", nhs, 64);
        chk("T2 parity", par_data[0], golden(0));

        // T4: parity backpressure
        held = par_data[0];
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1 par_ready[0] = 1'b0;
            @(negedge clk);
            chk("T4 par_valid held", par_valid[0], 1'b1);
            chk("T4 par_data held", par_data[0], held);
        end
        @(posedge clk);
        #1 par_ready[0] = 1'b1;
        @(negedge clk);
        chk("T4 busy on handshake", busy[0], 1'b1);
        @(posedge clk);
        #1 par_ready[0] = 1'b0;
        @(negedge clk);
        chk("T4 idle after handshake", {busy[0], par_valid[0]}, 2'b00);
        @(posedge clk);
        #1;

        // T3: five-cycle stall at byte 17 of block 0
        run_small(20, 24, -1, -1);
        errs = 0;
        for (int c = 20; c <= 24; c++)
            if (snap[c][4] || snap[c][2]) errs++;
        chk("T3 stall en errors", errs, 0);
        chk("T3 en_L around stall", {snap[19][2], snap[25][2]}, 2'b11);
        chk("T3 par_valid cycle", pv_cyc, 73);
        chk("T3 handshakes", nhs, 64);
        chk("T3 parity", par_data[0], golden(0));
        @(posedge clk);
        #1 par_ready[0] = 1'b1;
        @(posedge clk);
        #1 par_ready[0] = 1'b0;

        // T5: start during DATA and on the DONE handshake is ignored
        run_small(-1, -2, 10, -1);
        errs = 0;
        for (int c = 0; c < 200; c++)
            if (snap[c][6] && !snap[c][5]) errs++;
        chk("T5 single CLR", errs, 1);
        chk("T5 par_valid cycle", pv_cyc, 68);
        @(posedge clk);
        #1;
        par_ready[0] = 1'b1;
        start[0]     = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        errs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (busy[0] || !rst_c[0] || par_valid[0]) errs++;
            @(posedge clk);
            #1;
        end
        par_ready[0] = 1'b0;
        chk("T5 stays idle", errs, 0);

        // T6: full 32-block codewords with random valid gaps and random parity backpressure
        for (int cw = 0; cw < 20; cw++) begin
            msgq.delete();
            start[1] = 1'b1;
            @(posedge clk);
            #1 start[1] = 1'b0;
            done = 0;
            for (int c = 0; c < 6000 && done == 0; c++) begin
                msg_valid[1] = ($urandom_range(0, 3) != 0);
                msg_data[1]  = 8'($urandom);
                @(negedge clk);
                if (msg_valid[1] && msg_ready[1]) msgq.push_back(msg_data[1]);
                if (par_valid[1]) done = 1;
                else begin
                    @(posedge clk);
                    #1;
                end
            end
            chk($sformatf("T6 cw%0d done", cw), done, 1);
            if (done == 0) break;
            chk($sformatf("T6 cw%0d bytes", cw), msgq.size(), 1024);
            chk($sformatf("T6 cw%0d parity", cw), par_data[1], golden(1));
            held    = par_data[1];
            hs_seen = 0;
            errs    = 0;
            for (int k = 0; k < 50 && hs_seen == 0; k++) begin
                @(posedge clk);
                #1;
                par_ready[1] = 1'($urandom_range(0, 1));
                msg_valid[1] = 1'($urandom_range(0, 1));
                @(negedge clk);
                if (!par_valid[1] || msg_ready[1] || par_data[1] !== held) errs++;
                if (par_valid[1] && par_ready[1]) hs_seen = 1;
            end
            chk($sformatf("T6 cw%0d hold errors", cw), errs, 0);
            chk($sformatf("T6 cw%0d drained", cw), hs_seen, 1);
            @(posedge clk);
            #1;
            par_ready[1] = 1'b0;
            msg_valid[1] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
